// File: rtl/count_display_scan.sv
`timescale 1ns/1ps
// count_display_scan: snapshots an unsettled 16-bit ripple-counter value
// and scans it onto a 4-digit common-anode multiplexed hex 7-seg display.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   cnt_in[15:0]      counter value, may change on any edge
//   freeze            1 = hold the current snapshot; scanning continues
//   seg_n[6:0]        segments {g,f,e,d,c,b,a}, active-low, registered
//   an_n[3:0]         digit enables, active-low, registered; an_n[0] = nibble [3:0]
//   snap_valid        1-clk pulse the cycle after a new snapshot is latched
module count_display_scan #(
    parameter int PRESCALE      = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cnt_in,
    input  logic        freeze,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        snap_valid
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [15:0]   s1_q;
    logic [15:0]   s2_q;
    logic [15:0]   snap_q;
    logic [15:0]   snap_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [1:0]    dig_q;
    logic [1:0]    dig_d;
    logic          valid_q;
    logic          valid_d;
    logic [6:0]    seg_q;
    logic [6:0]    seg_d;
    logic [3:0]    an_q;
    logic [3:0]    an_d;

    logic          wrap;
    logic          fb;
    logic          stable;
    logic          load;
    logic [15:0]   shifted;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign wrap   = (presc_q == PMAX);
    assign fb     = wrap && (dig_q == 2'd3);
    // Two consecutive equal samples mean the ripple has settled.
    assign stable = (s1_q == s2_q);
    assign load   = fb && stable && !freeze;

    always_comb begin
        presc_d = presc_q + 1'b1;
        dig_d   = dig_q;
        snap_d  = snap_q;
        valid_d = load;
        if (wrap) begin
            presc_d = '0;
            dig_d   = dig_q + 2'd1;
        end
        if (load) begin
            snap_d = s2_q;
        end
    end

    // shifted holds snap[15:4*dig]; zero means every digit from here up is 0.
    always_comb begin
        shifted = snap_q >> {dig_q, 2'b00};
        nib     = shifted[3:0];
        blank   = BLANK_LEADING && (dig_q != 2'd0) && (shifted == 16'h0000);
        seg_d   = hex7(nib);
        an_d    = ~(4'b0001 << dig_q);
        if (blank) begin
            seg_d = 7'h7F;
            an_d  = 4'hF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            snap_q  <= '0;
            presc_q <= '0;
            dig_q   <= '0;
            valid_q <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
        end else begin
            s1_q    <= cnt_in;
            s2_q    <= s1_q;
            snap_q  <= snap_d;
            presc_q <= presc_d;
            dig_q   <= dig_d;
            valid_q <= valid_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign snap_valid = valid_q;

endmodule

// File: tb/tb_count_display_scan.sv
`timescale 1ns/1ps
// Bench for count_display_scan: reset, digit scan, blanking, unstable
// input, freeze and a behavioural ripple counter driving cnt_in.
module tb_count_display_scan;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } slot_t;

    typedef struct {
        logic [15:0]     cnt;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic [15:0] cnt_drv = 16'h0000;
    logic        use_rc = 1'b0;
    logic [15:0] dut_cnt;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        snap_valid;

    logic [15:0] rc = 16'hFF80;
    logic [15:0] rc_settled = 16'hFF80;
    logic        rc_run = 1'b0;
    int          rc_ph = 0;

    int          checks = 0;
    int          errors = 0;
    slot_t       sb[$];
    logic [3:0]  an_s [16];
    logic [6:0]  seg_s [16];
    logic        sv_s [16];
    bit          tog_en = 1'b0;
    vec_t        vt [7];

    assign dut_cnt = use_rc ? rc : cnt_drv;

    always #5 clk = ~clk;

    count_display_scan #(
        .PRESCALE(4),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cnt_in(dut_cnt),
        .freeze(freeze),
        .seg_n(seg_n),
        .an_n(an_n),
        .snap_valid(snap_valid)
    );

    // Ripple counter: bit k settles 1 ns after bit k-1, one count per 5 clks.
    initial begin
        logic [15:0] nxt;
        forever begin
            @(posedge clk);
            if (rc_run) begin
                rc_ph = rc_ph + 1;
                if (rc_ph == 5) begin
                    rc_ph = 0;
                    nxt = rc + 16'd1;
                    for (int k = 0; k < 16; k++) begin
                        if (rc[k] == nxt[k]) break;
                        #1;
                        rc[k] = nxt[k];
                    end
                    rc_settled = nxt;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;
            4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;
            4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;
            4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;
            4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [10:0] exp_slot(input logic [15:0] v, input int k);
        logic [15:0] up;
        up = v >> (4 * k);
        if (k > 0 && up == 16'h0000) return {4'hF, 7'h7F};
        return {~(4'b0001 << k), hex7(up[3:0])};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_pulse(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            seen = snap_valid;
        end
        chk("snap_valid_timeout", seen, 1);
    endtask

    // Samples the 16 cycles of the frame following a pulse seen at a negedge.
    task automatic grab();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            an_s[i]  = an_n;
            seg_s[i] = seg_n;
            sv_s[i]  = snap_valid;
        end
    endtask

    task automatic check_sb(input string nm);
        slot_t e;
        bit    anyp;
        anyp = 1'b0;
        for (int i = 0; i < 15; i++) anyp |= sv_s[i];
        chk({nm, "_midframe_pulse"}, anyp, 0);
        for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) begin
                chk({nm, "_sb_empty"}, 0, 1);
            end else begin
                e = sb.pop_front();
                for (int j = 0; j < 4; j++)
                    chk($sformatf("%s_dig%0d_slot%0d", nm, k, j),
                        {an_s[4*k+j], seg_s[4*k+j]}, {e.an, e.seg});
            end
        end
    endtask

    task automatic push_val(input logic [15:0] v);
        logic [10:0] x;
        for (int k = 0; k < 4; k++) begin
            x = exp_slot(v, k);
            sb.push_back('{an: x[10:7], seg: x[6:0]});
        end
    endtask

    task automatic decode_frame(output logic [15:0] v);
        logic [3:0] nib;
        v = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            nib = 4'h0;
            if (an_s[4*k] != 4'hF)
                for (int n = 0; n < 16; n++)
                    if (hex7(4'(n)) == seg_s[4*k]) nib = 4'(n);
            v[4*k +: 4] = nib;
        end
        for (int i = 0; i < 16; i++)
            chk($sformatf("ripple_frame_slot%0d", i),
                {an_s[i], seg_s[i]}, exp_slot(v, i / 4));
    endtask

    initial begin
        int          n;
        bit          svl;
        int          t6;
        logic [15:0] v;
        logic [15:0] last;
        logic [15:0] d;
        logic [15:0] lim;
        slot_t       e;

        vt[0] = '{16'h1A3F, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'h79, 7'h08, 7'h30, 7'h0E}};
        vt[1] = '{16'h0005, {4'hF, 4'hF, 4'hF, 4'b1110},
                  {7'h7F, 7'h7F, 7'h7F, 7'h12}};
        vt[2] = '{16'h0000, {4'hF, 4'hF, 4'hF, 4'b1110},
                  {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vt[3] = '{16'h0B00, {4'hF, 4'b1011, 4'b1101, 4'b1110},
                  {7'h7F, 7'h03, 7'h40, 7'h40}};
        vt[4] = '{16'hC0D0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'h46, 7'h40, 7'h21, 7'h40}};
        vt[5] = '{16'h8765, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'h00, 7'h78, 7'h02, 7'h12}};
        vt[6] = '{16'h0042, {4'hF, 4'hF, 4'b1101, 4'b1110},
                  {7'h7F, 7'h7F, 7'h19, 7'h24}};

        // Reset held across clock edges, then first cycle after release.
        repeat (2) @(negedge clk);
        chk("reset_dark", {snap_valid, an_n, seg_n}, {1'b0, 4'hF, 7'h7F});
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_cycle", {an_n, seg_n}, {4'b1110, 7'h40});

        // Asynchronous reset mid-frame, checked before any clock edge.
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {snap_valid, an_n, seg_n}, {1'b0, 4'hF, 7'h7F});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_release", {an_n, seg_n}, {4'b1110, 7'h40});
        @(negedge clk);

        // Vector table: each value gets one full frame checked.
        for (int i = 0; i < 7; i++) begin
            cnt_drv = vt[i].cnt;
            for (int k = 0; k < 4; k++) begin
                e.an  = vt[i].an[k];
                e.seg = vt[i].seg[k];
                sb.push_back(e);
            end
            wait_pulse(n);
            grab();
            check_sb($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_period16", i), sv_s[15], 1);
        end

        // Input toggling every clk across frame boundaries.
        cnt_drv = 16'h1A3F;
        push_val(16'h1A3F);
        wait_pulse(n);
        grab();
        check_sb("tog_pre");
        chk("tog_pre_period", sv_s[15], 1);
        cnt_drv = 16'h00FF;
        tog_en = 1'b1;
        fork
            begin
                while (1) begin
                    @(posedge clk);
                    #2;
                    if (!tog_en) break;
                    cnt_drv = (cnt_drv == 16'h00FF) ? 16'h0100 : 16'h00FF;
                end
            end
        join_none
        for (int f = 0; f < 2; f++) begin
            push_val(16'h1A3F);
            grab();
            check_sb($sformatf("tog_frame%0d", f));
            chk($sformatf("tog_frame%0d_no_pulse", f), sv_s[15], 0);
        end
        tog_en = 1'b0;
        @(negedge clk);
        cnt_drv = 16'h0100;
        push_val(16'h0100);
        wait_pulse(n);
        grab();
        check_sb("tog_post");

        // Freeze holds the snapshot for three frames.
        cnt_drv = 16'h0001;
        push_val(16'h0001);
        wait_pulse(n);
        grab();
        check_sb("frz_pre");
        freeze = 1'b1;
        cnt_drv = 16'h0002;
        for (int f = 0; f < 3; f++) begin
            push_val(16'h0001);
            grab();
            check_sb($sformatf("frz_frame%0d", f));
            chk($sformatf("frz_frame%0d_no_pulse", f), sv_s[15], 0);
        end
        freeze = 1'b0;
        push_val(16'h0002);
        wait_pulse(n);
        chk("frz_release_next_fb", n, 16);
        grab();
        check_sb("frz_post");

        // Ripple counter upstream: snapshots settled and non-decreasing.
        use_rc = 1'b1;
        rc_run = 1'b1;
        svl = 1'b0;
        t6 = 0;
        last = 16'hFF80;
        while (t6 < 2000) begin
            if (!svl) begin
                wait_pulse(n);
                t6 += n;
            end
            grab();
            t6 += 16;
            decode_frame(v);
            d = v - last;
            lim = rc_settled - last;
            chk("ripple_monotonic", d <= lim, 1);
            last = v;
            svl = sv_s[15];
        end
        d = last - 16'hFF80;
        chk("ripple_progress", d >= 16'd350, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
